// File: rtl/psg_wr_arb.sv
// psg_wr_arb: two-requester write-port arbiter for an SN76489-style PSG.
// `PSG_WR_ARB_RELATCH_CNT_EN adds a saturating relatch_cnt output.
module psg_wr_arb #(
  parameter int unsigned WR_GAP      = 2,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  a_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [7:0]  b_data,
  input  logic        b_valid,
  output logic        b_ready,
  output logic [7:0]  psg_wrdata,
  output logic        psg_wren
`ifdef PSG_WR_ARB_RELATCH_CNT_EN
  ,
  output logic [15:0] relatch_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RELATCH,
    S_DATA,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LD =
    (WR_GAP == 0) ? 4'd0 : 4'(WR_GAP - 1);
  localparam logic [7:0] LOCK_LD = 8'(LOCK_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_gap_cnt;
  logic [7:0]  r_byte;
  logic        r_own;
  logic        r_pend;
  logic [1:0]  r_latch;
  logic [1:0]  r_a_ch;
  logic [1:0]  r_b_ch;
  logic [3:0]  r_shadow [4];
  logic        r_lock_act;
  logic        r_lock_own;
  logic [7:0]  r_lock_cnt;
  logic        r_a_ready;
  logic        r_b_ready;
  logic        r_wren;
  logic [7:0]  r_wrdata;

  logic        w_a_elig;
  logic        w_b_elig;
  logic        w_acc;
  logic        w_sel_b;
  logic [7:0]  w_in;
  logic [1:0]  w_in_ch;
  logic [1:0]  w_own_ch;

  // Lock owner bit: 0 = A, 1 = B.
  assign w_a_elig = a_valid & (~r_lock_act | ~r_lock_own);
  assign w_b_elig = b_valid & (~r_lock_act | r_lock_own);
  assign w_acc    = (r_state == S_IDLE) & ~r_a_ready & ~r_b_ready
                  & (w_a_elig | w_b_elig);
  assign w_sel_b  = ~w_a_elig;
  assign w_in     = w_sel_b ? b_data : a_data;
  assign w_in_ch  = w_sel_b ? r_b_ch : r_a_ch;
  assign w_own_ch = r_own ? r_b_ch : r_a_ch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_in[7])                w_next = S_DATA;
          else if (w_in_ch == 2'd3)   w_next = S_IDLE;
          else if (w_in_ch == r_latch) w_next = S_DATA;
          else                        w_next = S_RELATCH;
        end
      end
      S_RELATCH: w_next = (WR_GAP == 0) ? S_DATA : S_GAP;
      S_DATA:    w_next = (WR_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP: begin
        if (r_gap_cnt == 4'd0) w_next = r_pend ? S_DATA : S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap_cnt  <= '0;
      r_byte     <= '0;
      r_own      <= 1'b0;
      r_pend     <= 1'b0;
      r_latch    <= '0;
      r_a_ch     <= '0;
      r_b_ch     <= '0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= '0;
      r_lock_act <= 1'b0;
      r_lock_own <= 1'b0;
      r_lock_cnt <= '0;
      r_a_ready  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_wren     <= 1'b0;
      r_wrdata   <= '0;
    end else begin
      r_a_ready <= 1'b0;
      r_b_ready <= 1'b0;
      r_wren    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_a_ready <= ~w_sel_b;
            r_b_ready <= w_sel_b;
            r_byte    <= w_in;
            r_own     <= w_sel_b;
            r_pend    <= 1'b0;
            if (r_lock_act && (r_lock_own == w_sel_b))
              r_lock_act <= 1'b0;
            if (w_in[7]) begin
              if (w_sel_b) r_b_ch <= w_in[6:5];
              else         r_a_ch <= w_in[6:5];
              r_latch <= w_in[6:5];
              if (!w_in[4]) r_shadow[w_in[6:5]] <= w_in[3:0];
            end else if (w_in_ch != 2'd3 && w_in_ch != r_latch) begin
              r_pend <= 1'b1;
            end
          end else if (r_lock_act) begin
            r_lock_cnt <= r_lock_cnt - 8'd1;
            if (r_lock_cnt == 8'd1) r_lock_act <= 1'b0;
          end
        end
        S_RELATCH: begin
          r_wren    <= 1'b1;
          r_wrdata  <= {1'b1, w_own_ch, 1'b0, r_shadow[w_own_ch]};
          r_latch   <= w_own_ch;
          r_gap_cnt <= GAP_LD;
        end
        S_DATA: begin
          r_wren    <= 1'b1;
          r_wrdata  <= r_byte;
          r_pend    <= 1'b0;
          r_gap_cnt <= GAP_LD;
          // Only a requester's own frequency latch arms the lock.
          if (r_byte[7]) begin
            if (!r_byte[4] && r_byte[6:5] != 2'd3) begin
              r_lock_act <= 1'b1;
              r_lock_own <= r_own;
              r_lock_cnt <= LOCK_LD;
            end else begin
              r_lock_act <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign a_ready    = r_a_ready;
  assign b_ready    = r_b_ready;
  assign psg_wren   = r_wren;
  assign psg_wrdata = r_wrdata;

`ifdef PSG_WR_ARB_RELATCH_CNT_EN
  logic [15:0] r_rl_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rl_cnt <= '0;
    end else if (r_state == S_RELATCH && r_rl_cnt != 16'hFFFF) begin
      r_rl_cnt <= r_rl_cnt + 16'd1;
    end
  end

  assign relatch_cnt = r_rl_cnt;
`endif

endmodule

// File: tb/tb_psg_wr_arb.sv
// tb_psg_wr_arb: directed vector table plus hand sequences for psg_wr_arb.
module tb_psg_wr_arb;

  localparam int WR_GAP = 2;
  localparam int LOCK   = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] psg_wrdata;
  logic       psg_wren;
`ifdef PSG_WR_ARB_RELATCH_CNT_EN
  logic [15:0] relatch_cnt;
`endif

  psg_wr_arb #(
    .WR_GAP(WR_GAP),
    .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_data(a_data),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .b_data(b_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .psg_wrdata(psg_wrdata),
    .psg_wren(psg_wren)
`ifdef PSG_WR_ARB_RELATCH_CNT_EN
    ,
    .relatch_cnt(relatch_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic [7:0] q[$];
  int qt[$];
  int a_rdy_n = 0;
  int b_rdy_n = 0;
  int a_rdy_cyc = 0;
  int b_rdy_cyc = 0;

  // Monitor: stamps every write pulse and ready strobe with a cycle number.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (psg_wren) begin
      q.push_back(psg_wrdata);
      qt.push_back(cyc);
    end
    if (a_ready) begin a_rdy_n++; a_rdy_cyc = cyc; end
    if (b_ready) begin b_rdy_n++; b_rdy_cyc = cyc; end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input bit is_b, input logic [7:0] d,
                      output int rc);
    int n0;
    bit ok;
    n0 = is_b ? b_rdy_n : a_rdy_n;
    if (is_b) begin b_data = d; b_valid = 1'b1; end
    else      begin a_data = d; a_valid = 1'b1; end
    ok = 1'b0;
    rc = -1;
    for (int k = 0; k < 400 && !ok; k++) begin
      tick();
      ok = ((is_b ? b_rdy_n : a_rdy_n) != n0);
    end
    if (is_b) b_valid = 1'b0;
    else      a_valid = 1'b0;
    if (ok) rc = is_b ? b_rdy_cyc : a_rdy_cyc;
    chk($sformatf("%s_ready_%02h", is_b ? "b" : "a", d), int'(ok), 1);
  endtask

  task automatic get_byte(input string nm, input logic [7:0] e,
                          output int t);
    int k;
    logic [7:0] d;
    k = 0;
    t = -1;
    while (q.size() == 0 && k < 300) begin
      tick();
      k++;
    end
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no write seen, want %02h", nm, e);
    end else begin
      d = q.pop_front();
      t = qt.pop_front();
      chk(nm, int'(d), int'(e));
    end
  endtask

  typedef struct {
    bit         is_b;
    logic [7:0] d;
    int         n;
    logic [7:0] e0;
    logic [7:0] e1;
    bit         quiet;
  } vec_t;

  vec_t tv[8];

  initial begin
    int rc, t, tp, ra, rb;
    reset   = 1'b0;
    a_data  = '0;
    a_valid = 1'b0;
    b_data  = '0;
    b_valid = 1'b0;
    #1 reset = 1'b1;

    tv[0] = '{1'b0, 8'h8A, 1, 8'h8A, 8'h00, 1'b0};
    tv[1] = '{1'b0, 8'h05, 1, 8'h05, 8'h00, 1'b1};
    tv[2] = '{1'b0, 8'h87, 1, 8'h87, 8'h00, 1'b1};
    tv[3] = '{1'b1, 8'hA2, 1, 8'hA2, 8'h00, 1'b1};
    tv[4] = '{1'b1, 8'h01, 1, 8'h01, 8'h00, 1'b1};
    tv[5] = '{1'b0, 8'h10, 2, 8'h87, 8'h10, 1'b1};
    tv[6] = '{1'b0, 8'hE4, 1, 8'hE4, 8'h00, 1'b1};
    tv[7] = '{1'b0, 8'h3F, 0, 8'h00, 8'h00, 1'b1};

    repeat (3) tick();
    chk("rst_wren", int'(psg_wren), 0);
    chk("rst_wrdata", int'(psg_wrdata), 0);
    chk("rst_a_ready", int'(a_ready), 0);
    chk("rst_b_ready", int'(b_ready), 0);
    reset = 1'b0;
    tick();

    // Simultaneous requests: A first, B after A's write and gap.
    fork
      send(1'b0, 8'h9F, ra);
      send(1'b1, 8'hBF, rb);
    join
    chk("simul_order", rb - ra, WR_GAP + 2);
    get_byte("simul_a", 8'h9F, t);
    get_byte("simul_b", 8'hBF, t);
    repeat (WR_GAP + 4) tick();

    tp = -100;
    for (int i = 0; i < 8; i++) begin
      send(tv[i].is_b, tv[i].d, rc);
      for (int j = 0; j < tv[i].n; j++) begin
        get_byte($sformatf("v%0d_byte%0d", i, j),
                 (j == 0) ? tv[i].e0 : tv[i].e1, t);
        if (j == 0) chk($sformatf("v%0d_latency", i), t, rc + 1);
        n_chk++;
        if (t - tp < WR_GAP + 1) begin
          n_fail++;
          $display("FAIL v%0d_spacing: got %0d, want >= %0d",
                   i, t - tp, WR_GAP + 1);
        end
        tp = t;
      end
      if (tv[i].quiet) begin
        repeat (WR_GAP + 4) tick();
        chk($sformatf("v%0d_extra", i), q.size(), 0);
      end
    end
`ifdef PSG_WR_ARB_RELATCH_CNT_EN
    chk("relatch_cnt", int'(relatch_cnt), 1);
`endif

    // Lock: B waits while A owns the latch, A's data goes first.
    send(1'b0, 8'h83, rc);
    get_byte("lock_83", 8'h83, t);
    fork
      send(1'b1, 8'h9F, rb);
      begin
        repeat (10) tick();
        send(1'b0, 8'h12, ra);
      end
    join
    n_chk++;
    if (rb <= ra) begin
      n_fail++;
      $display("FAIL lock_order: b_ready at %0d, a_ready at %0d", rb, ra);
    end
    get_byte("lock_12", 8'h12, t);
    get_byte("lock_9f", 8'h9F, t);
    repeat (WR_GAP + 4) tick();

    // Timeout: gap, then LOCK idle cycles, then one decision cycle.
    send(1'b0, 8'h83, rc);
    get_byte("tmo_83", 8'h83, t);
    send(1'b1, 8'hBF, rb);
    chk("tmo_cycle", rb, t + WR_GAP + LOCK + 1);
    get_byte("tmo_bf", 8'hBF, t);
    repeat (WR_GAP + 4) tick();

    // Reset inside a gap clears outputs and the latch mirror.
    send(1'b0, 8'hC3, rc);
    get_byte("rstg_c3", 8'hC3, t);
    reset = 1'b1;
    #1;
    chk("rstg_wren", int'(psg_wren), 0);
    chk("rstg_wrdata", int'(psg_wrdata), 0);
    chk("rstg_a_ready", int'(a_ready), 0);
    chk("rstg_b_ready", int'(b_ready), 0);
`ifdef PSG_WR_ARB_RELATCH_CNT_EN
    chk("rstg_relatch_cnt", int'(relatch_cnt), 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    send(1'b0, 8'h05, rc);
    get_byte("rstg_05", 8'h05, t);
    chk("rstg_latency", t, rc + 1);
    repeat (WR_GAP + 4) tick();
    chk("rstg_extra", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
